// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam int unsigned MD_DATA_WIDTH = 32;
  localparam int unsigned MD_LATENCY    = MD_DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Controller-to-mult/div request and HI/LO result bundle.
interface mult_div_unit_if
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MD_DATA_WIDTH
);

  logic                  start;
  md_op_e                op;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  hi_we;
  logic                  lo_we;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, hi_we, lo_we, write_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, hi_we, lo_we, write_data,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// One FSM drives a single 2*DATA_WIDTH shift accumulator shared by both ops.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MD_DATA_WIDTH
) (
  input logic            clk,
  input logic            reset_n,
  mult_div_unit_if.slave md
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned AW = 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  function automatic logic [W-1:0] abs_val(input logic [W-1:0] x, input logic is_signed);
    return (is_signed && x[W-1]) ? W'(-x) : x;
  endfunction

  function automatic logic [W-1:0] neg_if(input logic [W-1:0] x, input logic neg);
    return neg ? W'(-x) : x;
  endfunction

  md_state_e     state;
  md_op_e        op_q;
  logic [AW-1:0] acc;
  logic [W-1:0]  opd;
  logic [CW-1:0] cnt;
  logic          neg_lo;
  logic          neg_hi;
  logic          busy_q;
  logic          done_q;
  logic          dbz_q;
  logic [W-1:0]  hi_q;
  logic [W-1:0]  lo_q;

  logic          signed_op_c;
  logic          sign_a_c;
  logic          sign_b_c;
  logic [W-1:0]  a_abs_c;
  logic [W-1:0]  b_abs_c;
  logic [W:0]    mul_sum_c;
  logic [AW-1:0] mul_next_c;
  logic [W:0]    rem_sh_c;
  logic [W:0]    diff_c;
  logic [AW-1:0] div_next_c;
  logic [AW-1:0] prod_c;
  logic          div_zero_c;
  logic [W-1:0]  hi_res_c;
  logic [W-1:0]  lo_res_c;

  // Operand conditioning at start: signed ops work on magnitudes.
  always_comb begin
    signed_op_c = ~md.op[0];
    sign_a_c    = signed_op_c & md.operand_a[W-1];
    sign_b_c    = signed_op_c & md.operand_b[W-1];
    a_abs_c     = abs_val(md.operand_a, signed_op_c);
    b_abs_c     = abs_val(md.operand_b, signed_op_c);
  end

  // One iteration of shift-add multiply and restoring divide.
  // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    mul_sum_c  = {1'b0, acc[AW-1:W]} + {1'b0, (acc[0] ? opd : {W{1'b0}})};
    mul_next_c = {mul_sum_c, acc[W-1:1]};
    rem_sh_c   = acc[AW-1:W-1];
    diff_c     = rem_sh_c - {1'b0, opd};
    div_next_c = diff_c[W] ? {rem_sh_c[W-1:0], acc[W-2:0], 1'b0}
                           : {diff_c[W-1:0],   acc[W-2:0], 1'b1};
  end

  // Sign correction; a zero divisor leaves the raw quotient/remainder untouched.
  always_comb begin
    prod_c     = neg_lo ? AW'(-acc) : acc;
    div_zero_c = op_q[1] && (opd == {W{1'b0}});
    if (op_q[1]) begin
      lo_res_c = div_zero_c ? {W{1'b1}} : neg_if(acc[W-1:0], neg_lo);
      hi_res_c = div_zero_c ? acc[AW-1:W] : neg_if(acc[AW-1:W], neg_hi);
    end else begin
      lo_res_c = prod_c[W-1:0];
      hi_res_c = prod_c[AW-1:W];
    end
  end

  // Control FSM and architectural state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_q   <= MD_MULT;
      acc    <= '0;
      opd    <= '0;
      cnt    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (md.hi_we) hi_q <= md.write_data;
          if (md.lo_we) lo_q <= md.write_data;
          if (md.start) begin
            op_q   <= md.op;
            cnt    <= '0;
            busy_q <= 1'b1;
            dbz_q  <= 1'b0;
            neg_lo <= sign_a_c ^ sign_b_c;
            neg_hi <= sign_a_c;
            if (md.op[1]) begin
              opd <= b_abs_c;
              acc <= {{W{1'b0}}, a_abs_c};
            end else begin
              opd <= a_abs_c;
              acc <= {{W{1'b0}}, b_abs_c};
            end
            state <= CALC;
          end
        end
        CALC: begin
          acc <= op_q[1] ? div_next_c : mul_next_c;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= FIXUP;
        end
        FIXUP: begin
          hi_q   <= hi_res_c;
          lo_q   <= lo_res_c;
          dbz_q  <= div_zero_c;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.busy        = busy_q;
  assign md.done        = done_q;
  assign md.div_by_zero = dbz_q;
  assign md.hi          = hi_q;
  assign md.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO,
// a monitor pops and compares on every done pulse.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_done = 0;
  exp_t sb[$];

  mult_div_unit_if #(.DATA_WIDTH(32)) md ();

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (md)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (md.done === 1'b1) begin
        n_done++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done with hi=0x%0h lo=0x%0h, expected none", md.hi, md.lo);
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"}, 64'(md.hi), 64'(e.hi));
          check({e.name, "_lo"}, 64'(md.lo), 64'(e.lo));
          check({e.name, "_dbz"}, 64'(md.div_by_zero), 64'(e.dbz));
        end
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the start edge.
  task automatic issue(input string name, input md_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edbz, input bit push);
    exp_t e;
    md.start     = 1'b1;
    md.op        = op;
    md.operand_a = a;
    md.operand_b = b;
    if (push) begin
      e.name = name; e.hi = ehi; e.lo = elo; e.dbz = edbz;
      sb.push_back(e);
    end
    @(negedge clk);
    md.start     = 1'b0;
    md.operand_a = 32'hA5A5_A5A5;
    md.operand_b = 32'h5A5A_5A5A;
  endtask

  // Waits for done (bounded); lat counts edges from the start edge to done.
  task automatic wait_done(input string name, output int lat, output int busy_c);
    int c;
    c = 1;
    busy_c = 0;
    lat = -1;
    while (c <= 100) begin
      if (md.busy === 1'b1) busy_c++;
      if (md.done === 1'b1) begin
        lat = c - 1;
        return;
      end
      @(negedge clk);
      c++;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s_timeout: got no done in 100 cycles, expected done", name);
  endtask

  initial begin
    int lat, busy_c, done_before;
    reset_n       = 1'b0;
    md.start      = 1'b0;
    md.op         = MD_MULT;
    md.operand_a  = '0;
    md.operand_b  = '0;
    md.hi_we      = 1'b0;
    md.lo_we      = 1'b0;
    md.write_data = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_busy", 64'(md.busy), 64'd0);
    check("rst_done", 64'(md.done), 64'd0);
    check("rst_dbz", 64'(md.div_by_zero), 64'd0);
    check("rst_hi", 64'(md.hi), 64'd0);
    check("rst_lo", 64'(md.lo), 64'd0);

    issue("mult_neg3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
    wait_done("mult_neg3x7", lat, busy_c);
    check("mult_latency", 64'(lat), 64'(MD_LATENCY));
    check("mult_busy_cycles", 64'(busy_c), 64'(MD_LATENCY));
    @(negedge clk);
    check("busy_low_after_done", 64'(md.busy), 64'd0);

    issue("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
    wait_done("multu_max", lat, busy_c);
    @(negedge clk);
    issue("mult_m1xm1", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 1'b1);
    wait_done("mult_m1xm1", lat, busy_c);
    @(negedge clk);
    issue("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
    wait_done("div_neg7_2", lat, busy_c);
    check("div_latency", 64'(lat), 64'(MD_LATENCY));
    @(negedge clk);
    issue("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    wait_done("divu_100_7", lat, busy_c);
    @(negedge clk);
    issue("divu_by0", MD_DIVU, 32'h64, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done("divu_by0", lat, busy_c);
    check("div0_latency", 64'(lat), 64'(MD_LATENCY));
    @(negedge clk);
    check("dbz_held_idle", 64'(md.div_by_zero), 64'd1);
    issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b1);
    check("dbz_cleared_on_start", 64'(md.div_by_zero), 64'd0);
    wait_done("div_ovf", lat, busy_c);
    @(negedge clk);

    // Contention: second start and MTHI while busy must be ignored.
    done_before = n_done;
    issue("mult_6x7", MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    md.start      = 1'b1;
    md.op         = MD_DIVU;
    md.operand_a  = 32'd9;
    md.operand_b  = 32'd0;
    md.hi_we      = 1'b1;
    md.write_data = 32'hDEAD_BEEF;
    @(negedge clk);
    md.start = 1'b0;
    md.hi_we = 1'b0;
    check("busy_hi_hold", 64'(md.hi), 64'h0);
    check("busy_lo_hold", 64'(md.lo), 64'h8000_0000);
    wait_done("mult_6x7", lat, busy_c);
    repeat (40) @(negedge clk);
    check("single_done", 64'(n_done - done_before), 64'd1);

    // MTHI/MTLO in IDLE land on the next edge.
    md.hi_we      = 1'b1;
    md.write_data = 32'h1234;
    @(negedge clk);
    md.hi_we = 1'b0;
    check("mthi_idle", 64'(md.hi), 64'h1234);
    md.lo_we      = 1'b1;
    md.write_data = 32'h5678;
    @(negedge clk);
    md.lo_we = 1'b0;
    check("mtlo_idle", 64'(md.lo), 64'h5678);
    check("mtlo_keeps_hi", 64'(md.hi), 64'h1234);

    // Reset mid-divide: abort immediately, no done.
    issue("div_abort", MD_DIV, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_hi", 64'(md.hi), 64'd0);
    check("abort_lo", 64'(md.lo), 64'd0);
    check("abort_busy", 64'(md.busy), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(md.busy), 64'd0);

    issue("multu_3x5", MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);
    wait_done("multu_3x5", lat, busy_c);
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the single-cycle MIPS core, executing MULT, MULTU, DIV and DIVU.
- Holds the architectural HI/LO registers.
- Its hi/lo outputs feed the register-file write-data mux for MFHI/MFLO; operands come from the register-file read ports.
- Main decoder starts operations and stalls the PC on busy.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width; iteration count = DATA_WIDTH

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_a  input  DATA_WIDTH  rs value (multiplicand / dividend)
operand_b  input  DATA_WIDTH  rt value (multiplier / divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
write_data  input  DATA_WIDTH  MTHI/MTLO data
busy  output  1  operation in progress; controller stalls
done  output  1  one-cycle pulse, HI/LO just updated
div_by_zero  output  1  valid with done: last DIV/DIVU had operand_b = 0
hi  output  DATA_WIDTH  HI register
lo  output  DATA_WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous, active-low.
- Reset state: state=IDLE; hi, lo, internal accumulators and counter = 0; busy=0, done=0, div_by_zero=0.
- Reset mid-operation aborts immediately. HI/LO return 0 and no done pulse is produced.

State machine: IDLE -> CALC -> FIXUP -> IDLE.
- IDLE:
  - On start=1 at edge E0: latch op and the absolute values of the operands. Signed ops take two's-complement abs; unsigned ops pass operands unchanged.
  - Also latch the result signs and clear the counter. Go to CALC.
- CALC:
  - One iteration per edge, E1..E32.
  - Multiply: shift-add into a 2*DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter reaching DATA_WIDTH-1 -> FIXUP.
- FIXUP (edge E33):
  - Apply sign correction and write HI/LO.
  - Pulse done for one cycle. Return to IDLE.
- busy = (state != IDLE): high in cycles E0..E33, 33 cycles total. Latency = DATA_WIDTH+1 edges from start to done.

Result rules (all arithmetic wraps modulo 2^DATA_WIDTH):
- MULT/MULTU: {HI,LO} = full 64-bit product. For MULT, the product is negated if the operand signs differ.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Quotient is negated if the signs differ (DIV only).
  - Remainder takes the sign of the dividend.
- Divide by zero (operand_b = 0):
  - Runs the full latency.
  - LO = all ones, HI = operand_a as latched, no sign correction.
  - div_by_zero=1 alongside done.
  - div_by_zero is cleared on the next start.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.

Other rules:
- start while busy: ignored. Operands are captured only at E0; later operand changes have no effect.
- hi_we/lo_we:
  - In IDLE, write at the next edge.
  - While busy, ignored; the controller guarantees no MTHI/MTLO during busy.
  - If start and hi_we/lo_we arrive in the same IDLE cycle, both take effect. The later FIXUP overwrites HI/LO.
- hi/lo reads during busy return the previous result. HI/LO change only at FIXUP or on a write.

Decomposition:
- Shared package:
  - op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - State encoding IDLE/CALC/FIXUP.
  - Latency constant MD_LATENCY = DATA_WIDTH+1.
- No sub-module: one FSM plus a shared shift datapath. The abs/negate helpers are local functions.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> done exactly 33 edges after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; also MULT with the same operands -> HI=0, LO=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=100, b=7 -> LO=14, HI=2; div_by_zero=0.
- DIVU a=0x64, b=0 -> done with div_by_zero=1, LO=0xFFFFFFFF, HI=0x64; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Contention:
  - Second start at cycle 5 of a busy MULT 6*7 is ignored; result HI=0, LO=42 with a single done.
  - hi_we during busy does not change hi.
  - In IDLE, hi_we with write_data=0x1234 -> hi=0x1234 next cycle.
- Deassert reset_n at cycle 10 of a DIV -> immediately hi=lo=0, busy=0, and no done pulse; after reset release, a fresh MULTU 3*5 gives LO=15.
